// File: rtl/delay_line_pkg.sv
// Shared definitions for the multi-tap delay line: FSM encoding and
// constant helpers for sizing counters and locating tap slices.
package delay_line_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RD_RUN = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int tap_lsb(input int tap, input int width);
    return tap * width;
  endfunction

endpackage

// File: rtl/delay_line_if.sv
// Request/response bundle between the effect cores (master) and the
// multi-tap delay line (slave).
interface delay_line_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 4
) ();
  import delay_line_pkg::*;

  // Handshake: wr/rd (with data_in/offset) are taken only on a rising edge
  // where available=1, wr winning a tie; an untaken request must be held.
  // Completion is a one-cycle write_finish or read_finish pulse.
  logic                           wr;
  logic                           rd;
  logic [DATA_WIDTH-1:0]          data_in;
  logic [NUM_TAPS*ADDR_WIDTH-1:0] offset;
  logic [NUM_TAPS*DATA_WIDTH-1:0] data_out;
  logic                           write_finish;
  logic                           read_finish;
  logic                           available;
  logic                           full;
  state_t                         dbg_state;

  modport master (
    output wr, rd, data_in, offset,
    input  data_out, write_finish, read_finish, available, full, dbg_state
  );

  modport slave (
    input  wr, rd, data_in, offset,
    output data_out, write_finish, read_finish, available, full, dbg_state
  );

endinterface

// File: rtl/delay_line_mem.sv
// Single-port synchronous sample RAM; q follows addr by RAM_LAT cycles.
module delay_line_mem #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int RAM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] ram [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] stage [RAM_LAT];

  // No reset: unwritten contents are hidden by the fill level upstream.
  always_ff @(posedge clk) begin
    if (wren) ram[addr] <= wdata;
    stage[0] <= ram[addr];
    for (int i = 1; i < RAM_LAT; i++) stage[i] <= stage[i-1];
  end

  assign q = stage[RAM_LAT-1];

endmodule

// File: rtl/delay_line_mtap.sv
// Circular-buffer delay line, one write or one N-tap pipelined read per request.
// Optional macro DELAY_CLAMP_EN: taps beyond the fill level return the oldest sample.
module delay_line_mtap
  import delay_line_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 4,
  parameter int RAM_LAT    = 2
) (
  input  logic     clk,
  input  logic     rst,
  delay_line_if.slave bus
);

  localparam int AW      = ADDR_WIDTH;
  localparam int DW      = DATA_WIDTH;
  localparam int DEPTH   = 1 << AW;
  localparam int RUN_LEN = NUM_TAPS + RAM_LAT;
  localparam int CW      = clog2(RUN_LEN);
  localparam int IW      = (NUM_TAPS > 1) ? clog2(NUM_TAPS) : 1;

  state_t                 state, state_nxt;
  logic [AW-1:0]          head;
  logic [AW:0]            fill;
  logic                   op_rd;
  logic [DW-1:0]          wdata;
  logic [NUM_TAPS*AW-1:0] off_lat;
  logic [CW-1:0]          cnt;
  logic [NUM_TAPS*DW-1:0] dout;

  logic                   pipe_vld  [RAM_LAT];
  logic [IW-1:0]          pipe_idx  [RAM_LAT];
  logic                   pipe_zero [RAM_LAT];

  logic                   issue, issue_zero;
  logic [IW-1:0]          issue_idx;
  logic [AW-1:0]          tap_off, eff_off;
  logic                   mem_wren;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_q;

  always_comb begin
    issue     = (state == RD_RUN) && (cnt < CW'(NUM_TAPS));
    issue_idx = IW'(cnt);
    tap_off   = '0;
    for (int i = 0; i < NUM_TAPS; i++)
      if (cnt == CW'(i)) tap_off = off_lat[tap_lsb(i, AW) +: AW];
`ifdef DELAY_CLAMP_EN
    issue_zero = (fill == '0);
    eff_off    = ({1'b0, tap_off} >= fill) ? AW'(fill - (AW+1)'(1)) : tap_off;
`else
    issue_zero = ({1'b0, tap_off} >= fill);
    eff_off    = tap_off;
`endif
    mem_wren = (state == WRITE);
    // head points at the next free slot, so offset 0 lives at head-1.
    mem_addr = (state == WRITE) ? head : head - AW'(1) - eff_off;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.wr) state_nxt = WRITE;
               else if (bus.rd) state_nxt = RD_RUN;
      WRITE:   state_nxt = DONE;
      RD_RUN:  if (cnt == CW'(RUN_LEN - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      head    <= '0;
      fill    <= '0;
      op_rd   <= 1'b0;
      wdata   <= '0;
      off_lat <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (bus.wr) begin
          op_rd <= 1'b0;
          wdata <= bus.data_in;
        end else if (bus.rd) begin
          op_rd   <= 1'b1;
          off_lat <= bus.offset;
        end
      end
      if (state == WRITE) begin
        head <= head + AW'(1);
        if (fill != (AW+1)'(DEPTH)) fill <= fill + (AW+1)'(1);
      end
      cnt <= (state == RD_RUN) ? cnt + CW'(1) : '0;
    end
  end

  // Tap index and mask travel alongside the RAM so each q lands in its slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_idx[i]  <= '0;
        pipe_zero[i] <= 1'b0;
      end
      dout <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_idx[0]  <= issue_idx;
      pipe_zero[0] <= issue_zero;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
        pipe_zero[i] <= pipe_zero[i-1];
      end
      if (pipe_vld[RAM_LAT-1]) begin
        for (int t = 0; t < NUM_TAPS; t++)
          if (pipe_idx[RAM_LAT-1] == IW'(t))
            dout[tap_lsb(t, DW) +: DW] <= pipe_zero[RAM_LAT-1] ? '0 : mem_q;
      end
    end
  end

  delay_line_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RAM_LAT    (RAM_LAT)
  ) u_mem (
    .clk   (clk),
    .wren  (mem_wren),
    .addr  (mem_addr),
    .wdata (wdata),
    .q     (mem_q)
  );

  assign bus.data_out     = dout;
  assign bus.write_finish = (state == DONE) && !op_rd;
  assign bus.read_finish  = (state == DONE) && op_rd;
  assign bus.available    = (state == IDLE);
  assign bus.full         = (fill == (AW+1)'(DEPTH));
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_delay_line_mtap.sv
// Bench for delay_line_mtap: directed scenarios plus random traffic checked
// against a sample-history model of the delay line.
module tb_delay_line_mtap;
  import delay_line_pkg::*;

  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int NT     = 4;
  localparam int RL     = 2;
  localparam int DEPTH  = 1 << AW;
  localparam int RD_LAT = NT + RL + 1;
  localparam int WR_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  delay_line_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT)) dl ();

  delay_line_mtap #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_TAPS   (NT),
    .RAM_LAT    (RL)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dl)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0]    hist[$];
  logic [DW-1:0]    exp_q[$];
  logic [NT*DW-1:0] last_dout = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_tap(input int off);
    int f;
    int o;
    f = hist.size();
    o = off % DEPTH;
`ifdef DELAY_CLAMP_EN
    if (f == 0) return '0;
    if (o >= f) o = f - 1;
`else
    if (o >= f) return '0;
`endif
    return hist[f - 1 - o];
  endfunction

  task automatic model_write(input logic [DW-1:0] d);
    hist.push_back(d);
    if (hist.size() > DEPTH) hist.delete(0);
  endtask

  task automatic model_reset();
    hist.delete();
    last_dout = '0;
  endtask

  function automatic logic [NT*AW-1:0] pack_offs(input int o0, input int o1, input int o2, input int o3);
    return {AW'(o3), AW'(o2), AW'(o1), AW'(o0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (dl.available !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (dl.available !== 1'b1) check_eq("idle_timeout", dl.available, 1);
  endtask

  // Called just after the accepting edge; returns edges until the pulse is sampled.
  task automatic wait_finish(input bit is_rd, output int lat);
    int k = 0;
    while (((is_rd ? dl.read_finish : dl.write_finish) !== 1'b1) && k < 40) begin
      tick();
      k++;
    end
    lat = k + 1;
    check_eq(is_rd ? "rd_other_pulse" : "wr_other_pulse",
             is_rd ? dl.write_finish : dl.read_finish, 0);
  endtask

  task automatic finish_read(input logic [NT*AW-1:0] offs);
    int lat;
    logic [NT*DW-1:0] e;
    for (int t = 0; t < NT; t++) exp_q.push_back(model_tap(int'(offs[t*AW +: AW])));
    check_eq("rd_busy", dl.available, 0);
    wait_finish(1'b1, lat);
    check_eq("rd_latency", lat, RD_LAT);
    for (int t = 0; t < NT; t++) begin
      e[t*DW +: DW] = exp_q.pop_front();
      check_eq($sformatf("rd_tap%0d", t), dl.data_out[t*DW +: DW], e[t*DW +: DW]);
    end
    last_dout = e;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    int lat;
    wait_idle();
    dl.wr = 1'b1;
    dl.data_in = d;
    tick();
    dl.wr = 1'b0;
    dl.data_in = DW'($urandom);
    model_write(d);
    check_eq("wr_busy", dl.available, 0);
    wait_finish(1'b0, lat);
    check_eq("wr_latency", lat, WR_LAT);
  endtask

  task automatic do_read(input logic [NT*AW-1:0] offs);
    wait_idle();
    dl.rd = 1'b1;
    dl.offset = offs;
    tick();
    dl.rd = 1'b0;
    dl.offset = NT*AW'($urandom);
    finish_read(offs);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [DW-1:0] d;
    logic [NT*AW-1:0] offs;

    dl.wr = 1'b0;
    dl.rd = 1'b0;
    dl.data_in = '0;
    dl.offset = '0;
    rst = 1'b0;
    repeat (3) tick();
    check_eq("rst_available", dl.available, 1);
    check_eq("rst_full", dl.full, 0);
    check_eq("rst_data_out", dl.data_out, 0);
    check_eq("rst_write_finish", dl.write_finish, 0);
    check_eq("rst_read_finish", dl.read_finish, 0);
    rst = 1'b1;
    tick();

    // Empty buffer: every tap masked.
    do_read(pack_offs(0, 1, 2, 3));
    check_eq("empty_all_zero", dl.data_out, 0);

    // Three writes, one tap past the fill level.
    do_write(16'd10);
    do_write(16'd20);
    do_write(16'd30);
    do_read(pack_offs(0, 1, 2, 5));
    check_eq("fill3_t0", dl.data_out[0*DW +: DW], 30);
    check_eq("fill3_t1", dl.data_out[1*DW +: DW], 20);
    check_eq("fill3_t2", dl.data_out[2*DW +: DW], 10);
`ifdef DELAY_CLAMP_EN
    check_eq("fill3_t3", dl.data_out[3*DW +: DW], 10);
`else
    check_eq("fill3_t3", dl.data_out[3*DW +: DW], 0);
`endif

    // wr and rd together: write first, held rd taken at the next IDLE.
    wait_idle();
    dl.wr = 1'b1;
    dl.rd = 1'b1;
    dl.data_in = 16'd40;
    dl.offset = pack_offs(0, 1, 2, 3);
    tick();
    dl.wr = 1'b0;
    model_write(16'd40);
    check_eq("tie_busy", dl.available, 0);
    wait_finish(1'b0, lat);
    check_eq("tie_wr_latency", lat, WR_LAT);
    tick();
    check_eq("tie_idle_between", dl.available, 1);
    tick();
    dl.rd = 1'b0;
    finish_read(pack_offs(0, 1, 2, 3));
    check_eq("tie_t0", dl.data_out[0*DW +: DW], 40);
    check_eq("tie_t3", dl.data_out[3*DW +: DW], 10);

    // wr held high: one accepted write every third cycle.
    wait_idle();
    dl.wr = 1'b1;
    for (int t = 0; t < 15; t++) begin
      check_eq("b2b_write_finish", dl.write_finish, (t % 3) == 2);
      check_eq("b2b_available", dl.available, (t % 3) == 0);
      d = DW'($urandom);
      dl.data_in = d;
      if ((t % 3) == 0) model_write(d);
      tick();
    end
    dl.wr = 1'b0;
    check_eq("b2b_end_idle", dl.available, 1);
    do_read(pack_offs(0, 1, 4, 8));

    // Wrap-around and full flag.
    apply_reset();
    check_eq("rst2_full", dl.full, 0);
    for (int i = 1; i <= 20; i++) begin
      do_write(DW'(i));
      check_eq($sformatf("full_after_%0d", i), dl.full, i >= DEPTH);
    end
    do_read(pack_offs(0, 15, 3, 16));
    check_eq("wrap_t0", dl.data_out[0*DW +: DW], 20);
    check_eq("wrap_t1", dl.data_out[1*DW +: DW], 5);
    check_eq("wrap_t2", dl.data_out[2*DW +: DW], 17);
    check_eq("wrap_t3", dl.data_out[3*DW +: DW], 20);

    // Reset in the middle of a read aborts it silently.
    wait_idle();
    dl.rd = 1'b1;
    dl.offset = pack_offs(0, 1, 2, 3);
    tick();
    dl.rd = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("abort_read_finish", dl.read_finish, 0);
    check_eq("abort_data_out", dl.data_out, 0);
    check_eq("abort_available", dl.available, 1);
    check_eq("abort_full", dl.full, 0);
    tick();
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      check_eq("abort_no_pulse", dl.read_finish, 0);
      tick();
    end
    do_read(pack_offs(0, 0, 0, 0));
    check_eq("after_abort_zero", dl.data_out, 0);

    // Random traffic from an empty buffer through wrap.
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        do_write(DW'($urandom));
        check_eq("hold_data_out", dl.data_out, last_dout);
        check_eq("rand_full", dl.full, hist.size() == DEPTH);
      end else begin
        for (int t = 0; t < NT; t++) offs[t*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        do_read(offs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
